// File: rtl/pvr_ol_pkg.sv
// pvr_ol_pkg: Object List word encodings and sequencer state shared by OL walkers.
package pvr_ol_pkg;

    localparam logic [2:0] OL_TRI_ARRAY  = 3'b100;
    localparam logic [2:0] OL_QUAD_ARRAY = 3'b101;
    localparam logic [2:0] OL_RESERVED   = 3'b110;
    localparam logic [2:0] OL_LINK       = 3'b111;

    localparam int OL_STRIP_BIT = 31;
    localparam int OL_EOL_BIT   = 28;
    localparam int OL_OFS_MSB   = 20;
    localparam int OL_LINK_MSB  = 23;
    localparam int OL_LINK_LSB  = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_POLY,
        FINISH
    } ol_state_e;

endpackage

// File: rtl/ol_entry_decode.sv
// ol_entry_decode: classifies one OL word and derives its parameter and link addresses.
module ol_entry_decode
    import pvr_ol_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [23:0] param_base_i,
    output logic        is_poly_o,
    output logic        is_link_o,
    output logic        is_eol_o,
    output logic        is_reserved_o,
    output logic [23:0] poly_addr_o,
    output logic [23:0] link_addr_o
);

    logic [2:0] kind;
    logic       unused_bits;

    assign kind          = word_i[31:29];
    assign unused_bits   = ^{word_i[27:24], word_i[1:0]};
    assign is_poly_o     = !word_i[OL_STRIP_BIT] || kind == OL_TRI_ARRAY || kind == OL_QUAD_ARRAY;
    assign is_link_o     = kind == OL_LINK && !word_i[OL_EOL_BIT];
    assign is_eol_o      = kind == OL_LINK && word_i[OL_EOL_BIT];
    assign is_reserved_o = kind == OL_RESERVED;
    // Parameter offset is in words; the sum wraps within the 24-bit VRAM space.
    assign poly_addr_o   = param_base_i + {1'b0, word_i[OL_OFS_MSB:0], 2'b00};
    assign link_addr_o   = {word_i[OL_LINK_MSB:OL_LINK_LSB], 2'b00};

endmodule

// File: rtl/isp_ol_sequencer.sv
// isp_ol_sequencer: walks one tile's Object List in VRAM and hands each polygon
// entry to the ISP parser, following links until end-of-list, error or abort.
module isp_ol_sequencer
    import pvr_ol_pkg::*;
#(
    parameter int MAX_ENTRIES = 4096,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [23:0]      ol_base,
    input  logic [23:0]      param_base,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             list_error,
    output logic [CNT_W-1:0] entry_count,
    output logic             ol_vram_rd,
    output logic [23:0]      ol_vram_addr,
    input  logic [31:0]      ol_vram_din,
    input  logic             ol_vram_valid,
    output logic [31:0]      opb_word,
    output logic [23:0]      poly_addr,
    output logic             render_poly,
    input  logic             poly_drawn
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ENTRIES);

    ol_state_e        state_q;
    logic             busy_q, done_q, list_error_q, rd_q, render_q, abort_pend_q;
    logic [CNT_W-1:0] entry_count_q, entry_count_d;
    logic [23:0]      cur_addr_q, poly_addr_q;
    logic [31:0]      opb_word_q;
    logic             dec_poly, dec_link, dec_eol, dec_reserved;
    logic [23:0]      dec_poly_addr, dec_link_addr;
    logic             ab, unused_base;

    ol_entry_decode u_decode (
        .word_i        (opb_word_q),
        .param_base_i  (param_base),
        .is_poly_o     (dec_poly),
        .is_link_o     (dec_link),
        .is_eol_o      (dec_eol),
        .is_reserved_o (dec_reserved),
        .poly_addr_o   (dec_poly_addr),
        .link_addr_o   (dec_link_addr)
    );

    // An abort arriving this cycle counts as pending so it is never lost on a transition.
    assign ab            = abort_pend_q || abort;
    assign entry_count_d = (entry_count_q == MAX_C) ? entry_count_q : entry_count_q + CNT_W'(1);
    assign unused_base   = ^ol_base[1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            list_error_q  <= 1'b0;
            rd_q          <= 1'b0;
            render_q      <= 1'b0;
            abort_pend_q  <= 1'b0;
            entry_count_q <= '0;
            cur_addr_q    <= '0;
            poly_addr_q   <= '0;
            opb_word_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            render_q <= 1'b0;
            if (busy_q && abort)
                abort_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // done_q high means FINISH just ran; a coincident start is dropped.
                    if (start && !done_q) begin
                        cur_addr_q    <= {ol_base[23:2], 2'b00};
                        entry_count_q <= '0;
                        list_error_q  <= 1'b0;
                        abort_pend_q  <= 1'b0;
                        busy_q        <= 1'b1;
                        rd_q          <= 1'b1;
                        state_q       <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_q && ol_vram_valid) begin
                        opb_word_q    <= ol_vram_din;
                        rd_q          <= 1'b0;
                        entry_count_q <= entry_count_d;
                        state_q       <= ab ? FINISH : DECODE;
                    end
                end
                DECODE: begin
                    if (!ab && (entry_count_q == MAX_C || dec_reserved)) begin
                        list_error_q <= 1'b1;
                        state_q      <= FINISH;
                    end else if (dec_poly) begin
                        poly_addr_q <= dec_poly_addr;
                        state_q     <= ISSUE;
                    end else if (dec_link && !ab) begin
                        cur_addr_q <= dec_link_addr;
                        rd_q       <= 1'b1;
                        state_q    <= FETCH;
                    end else if (dec_eol || dec_reserved || ab) begin
                        state_q <= FINISH;
                    end
                end
                ISSUE: begin
                    render_q   <= 1'b1;
                    cur_addr_q <= cur_addr_q + 24'd4;
                    state_q    <= WAIT_POLY;
                end
                WAIT_POLY: begin
                    if (poly_drawn) begin
                        rd_q    <= !ab;
                        state_q <= ab ? FINISH : FETCH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign list_error   = list_error_q;
    assign entry_count  = entry_count_q;
    assign ol_vram_rd   = rd_q;
    assign ol_vram_addr = cur_addr_q;
    assign opb_word     = opb_word_q;
    assign poly_addr    = poly_addr_q;
    assign render_poly  = render_q;

endmodule

// File: tb/tb_isp_ol_sequencer.sv
// tb_isp_ol_sequencer: directed OL walks against a VRAM model with adjustable latency
// and a bench-driven parser handshake; expected values are hand-computed constants.
module tb_isp_ol_sequencer;

    logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, poly_drawn = 1'b0;
    logic [23:0] ol_base = '0, param_base = '0;
    logic        busy, done, list_error, ol_vram_rd, ol_vram_valid, render_poly;
    logic [15:0] entry_count;
    logic [23:0] ol_vram_addr, poly_addr;
    logic [31:0] ol_vram_din, opb_word;

    logic [31:0] mem [0:1023];
    int          lat = 0, wait_cnt = 0;
    int          checks = 0, failures = 0;

    int          r_np, r_nf;
    logic [23:0] r_fpa, r_lpa, r_lf;
    logic [31:0] r_fopb;
    logic        r_err, r_seen, r_busy;
    logic [15:0] r_cnt;

    typedef struct {
        logic [23:0] base;
        logic [23:0] pb;
        int          l;
        int          np;
        logic [23:0] fpa;
        logic [23:0] lpa;
        logic [31:0] fopb;
        logic        err;
        logic [15:0] cnt;
        int          nf;
        logic [23:0] lf;
    } vec_t;

    vec_t vecs [6];

    isp_ol_sequencer #(.MAX_ENTRIES(8), .CNT_W(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .ol_base       (ol_base),
        .param_base    (param_base),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .list_error    (list_error),
        .entry_count   (entry_count),
        .ol_vram_rd    (ol_vram_rd),
        .ol_vram_addr  (ol_vram_addr),
        .ol_vram_din   (ol_vram_din),
        .ol_vram_valid (ol_vram_valid),
        .opb_word      (opb_word),
        .poly_addr     (poly_addr),
        .render_poly   (render_poly),
        .poly_drawn    (poly_drawn)
    );

    always #5 clock = ~clock;

    assign ol_vram_valid = ol_vram_rd && (wait_cnt >= lat);
    assign ol_vram_din   = mem[ol_vram_addr[11:2]];

    always @(posedge clock) wait_cnt <= (ol_vram_rd && !ol_vram_valid) ? wait_cnt + 1 : 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    // Samples at each negedge until done; answers render_poly with poly_drawn two cycles later.
    task automatic monitor();
        int cd = 0;
        r_np = 0; r_nf = 0; r_fpa = '0; r_lpa = '0; r_lf = '0; r_fopb = '0;
        r_err = 1'b0; r_cnt = '0; r_seen = 1'b0; r_busy = 1'b1;
        for (int c = 0; c < 400 && !r_seen; c++) begin
            if (ol_vram_rd && ol_vram_valid) begin
                r_nf++;
                r_lf = ol_vram_addr;
            end
            if (render_poly) begin
                if (r_np == 0) begin
                    r_fpa  = poly_addr;
                    r_fopb = opb_word;
                end
                r_lpa = poly_addr;
                r_np++;
                cd = 2;
            end
            if (done) begin
                r_seen = 1'b1;
                r_err  = list_error;
                r_cnt  = entry_count;
                r_busy = busy;
            end
            poly_drawn = (cd == 1);
            if (cd > 0) cd--;
            if (!r_seen) @(negedge clock);
        end
        poly_drawn = 1'b0;
        chk("done_seen", 32'(r_seen), 32'd1);
    endtask

    task automatic run_vec(input int i);
        lat        = vecs[i].l;
        ol_base    = vecs[i].base;
        param_base = vecs[i].pb;
        pulse_start();
        monitor();
        chk($sformatf("v%0d_busy_at_done", i), 32'(r_busy), 32'd0);
        chk($sformatf("v%0d_polys", i), 32'(r_np), 32'(vecs[i].np));
        chk($sformatf("v%0d_first_poly_addr", i), 32'(r_fpa), 32'(vecs[i].fpa));
        chk($sformatf("v%0d_last_poly_addr", i), 32'(r_lpa), 32'(vecs[i].lpa));
        chk($sformatf("v%0d_opb_word", i), r_fopb, vecs[i].fopb);
        chk($sformatf("v%0d_list_error", i), 32'(r_err), 32'(vecs[i].err));
        chk($sformatf("v%0d_entry_count", i), 32'(r_cnt), 32'(vecs[i].cnt));
        chk($sformatf("v%0d_fetches", i), 32'(r_nf), 32'(vecs[i].nf));
        chk($sformatf("v%0d_last_fetch", i), 32'(r_lf), 32'(vecs[i].lf));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic bad;
        for (int a = 0; a < 1024; a++) mem[a] = 32'hF0000000;
        mem[12'h000 >> 2] = 32'h0C000010;
        mem[12'h004 >> 2] = 32'hF0000000;
        mem[12'h200 >> 2] = 32'h8A000020;
        mem[12'h204 >> 2] = 32'hE0000800;
        mem[12'h800 >> 2] = 32'hF0000000;
        mem[12'h300 >> 2] = 32'hE0000300;
        mem[12'h400 >> 2] = 32'hC0000000;
        mem[12'h500 >> 2] = 32'hA0000003;
        mem[12'h504 >> 2] = 32'h00000001;
        mem[12'h508 >> 2] = 32'hF0000000;
        mem[12'h600 >> 2] = 32'h001FFFFF;
        mem[12'h604 >> 2] = 32'hF0000000;

        vecs[0] = '{24'h000, 24'h100000, 0, 1, 24'h100040, 24'h100040, 32'h0C000010, 1'b0, 16'd2, 2, 24'h004};
        vecs[1] = '{24'h200, 24'h100000, 0, 1, 24'h100080, 24'h100080, 32'h8A000020, 1'b0, 16'd3, 3, 24'h800};
        vecs[2] = '{24'h400, 24'h000000, 1, 0, 24'h000000, 24'h000000, 32'h00000000, 1'b1, 16'd1, 1, 24'h400};
        vecs[3] = '{24'h300, 24'h000000, 0, 0, 24'h000000, 24'h000000, 32'h00000000, 1'b1, 16'd8, 8, 24'h300};
        vecs[4] = '{24'h502, 24'hFFFFF0, 2, 2, 24'hFFFFFC, 24'hFFFFF4, 32'hA0000003, 1'b0, 16'd3, 3, 24'h508};
        vecs[5] = '{24'h600, 24'hF00000, 0, 1, 24'h6FFFFC, 24'h6FFFFC, 32'h001FFFFF, 1'b0, 16'd2, 2, 24'h604};

        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", 32'(ol_vram_rd), 32'd0);
        chk("rst_render", 32'(render_poly), 32'd0);
        chk("rst_error", 32'(list_error), 32'd0);
        chk("rst_count", 32'(entry_count), 32'd0);
        chk("rst_addr", 32'(ol_vram_addr), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // VRAM stall: request and address must hold, nothing issued until data arrives.
        lat        = 5;
        ol_base    = 24'h000;
        param_base = 24'h100000;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_rd_%0d", i), 32'(ol_vram_rd), 32'd1);
            chk($sformatf("stall_addr_%0d", i), 32'(ol_vram_addr), 32'h000);
            chk($sformatf("stall_render_%0d", i), 32'(render_poly), 32'd0);
            @(negedge clock);
        end
        monitor();
        chk("stall_polys", 32'(r_np), 32'd1);
        chk("stall_poly_addr", 32'(r_fpa), 32'h100040);
        chk("stall_count", 32'(r_cnt), 32'd2);

        // Abort while waiting on the parser: done only after poly_drawn, no further fetch.
        lat = 0;
        pulse_start();
        for (int k = 0; k < 50 && !render_poly; k++) @(negedge clock);
        chk("abort_render_seen", 32'(render_poly), 32'd1);
        @(negedge clock) abort = 1'b1;
        @(negedge clock) abort = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            if (done || ol_vram_rd) bad = 1'b1;
            @(negedge clock);
        end
        chk("abort_waits_for_drawn", 32'(bad), 32'd0);
        chk("abort_still_busy", 32'(busy), 32'd1);
        poly_drawn = 1'b1;
        @(negedge clock) poly_drawn = 1'b0;
        monitor();
        chk("abort_no_fetch", 32'(r_nf), 32'd0);
        chk("abort_no_error", 32'(r_err), 32'd0);
        chk("abort_count", 32'(r_cnt), 32'd1);

        // Asynchronous reset in the middle of a stalled fetch.
        lat     = 20;
        ol_base = 24'h200;
        pulse_start();
        @(negedge clock);
        chk("prerst_rd", 32'(ol_vram_rd), 32'd1);
        chk("prerst_addr", 32'(ol_vram_addr), 32'h200);
        chk("prerst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd", 32'(ol_vram_rd), 32'd0);
        chk("midrst_addr", 32'(ol_vram_addr), 32'd0);
        chk("midrst_opb", opb_word, 32'd0);
        chk("midrst_poly_addr", 32'(poly_addr), 32'd0);
        @(negedge clock) reset_n = 1'b1;

        run_vec(0);
        // done is high at this negedge; a start now must be ignored.
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        chk("start_at_done_ignored", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        chk("start_at_done_no_fetch", 32'(ol_vram_rd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isp_ol_sequencer.md
Name: isp_ol_sequencer

Overview:
- Walks one tile's Object List (OL) in VRAM and drives the ISP polygon parser one entry at a time.
- Fetches each 32-bit OL word and decodes it as triangle strip, triangle array, quad array, link or end-of-list.
- For each polygon entry: presents opb_word and poly_addr, pulses render_poly, then waits for poly_drawn.
- Sits between the region-array/tile controller (above) and the ISP parser (below).

Parameters:
- MAX_ENTRIES, 4096: runaway guard; maximum OL words fetched per list before forced termination.
- CNT_W, 16: width of the entry counter; must satisfy 2^CNT_W > MAX_ENTRIES.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin a walk at ol_base. Ignored while busy.
- ol_base  in  24  byte address of the first OL word; bits 1:0 ignored.
- param_base  in  24  byte base of the ISP/TSP parameter buffer.
- abort  in  1  request early termination.
- busy  out  1  high from the start acceptance cycle until done.
- done  out  1  one-cycle pulse at list completion.
- list_error  out  1  latched at done; reserved type or MAX_ENTRIES hit. Cleared on next start.
- entry_count  out  CNT_W  OL words fetched in the current or last walk.
- ol_vram_rd  out  1  read request; held until ol_vram_valid.
- ol_vram_addr  out  24  word-aligned read address.
- ol_vram_din  in  32  read data.
- ol_vram_valid  in  1  read data valid; accepted only while ol_vram_rd is high.
- opb_word  out  32  current OL word to the parser; stable from render_poly until poly_drawn.
- poly_addr  out  24  parameter address to the parser.
- render_poly  out  1  one-cycle pulse to the parser.
- poly_drawn  in  1  parser completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; abort_pend 0.
- IDLE
  - On start: set cur_addr = {ol_base[23:2],2'b00}; clear entry_count, list_error and abort_pend; set busy; go to FETCH.
- FETCH
  - Assert ol_vram_rd with ol_vram_addr = cur_addr.
  - Hold both until ol_vram_valid.
  - On ol_vram_valid: latch the word into opb_word, drop ol_vram_rd the next cycle, increment entry_count, go to DECODE.
  - Minimum FETCH-to-DECODE is one cycle when valid is returned combinationally on the request cycle.
- DECODE (one cycle)
  - If entry_count == MAX_ENTRIES: set list_error, go to FINISH.
  - bit31 = 0 (strip): poly_addr = param_base + {opb_word[20:0],2'b00}, truncated to 24 bits. Go to ISSUE.
  - bits 31:29 = 100 (triangle array) or 101 (quad array): same poly_addr rule, go to ISSUE.
  - bits 31:29 = 111 (link):
    - If bit28 = 1 (end of list): go to FINISH.
    - Else: cur_addr = {opb_word[23:2],2'b00}, go to FETCH.
  - bits 31:29 = 110 (reserved): set list_error, go to FINISH.
- ISSUE
  - Pulse render_poly for one cycle.
  - Set cur_addr = cur_addr + 4 (wraps modulo 2^24).
  - Go to WAIT_POLY.
- WAIT_POLY
  - On poly_drawn: go to FINISH if abort_pend, else FETCH.
  - A poly_drawn pulse in any other state is ignored.
- FINISH
  - Pulse done; drop busy in the same cycle; go to IDLE.
- Abort
  - When abort is sampled high while busy, set abort_pend.
  - In FETCH: the outstanding read completes, then go to FINISH without issuing a polygon.
  - In DECODE or ISSUE: the polygon being issued still completes; then FINISH.
  - Abort in IDLE is ignored. An aborted walk does not set list_error.
- Simultaneous events
  - start together with done: start is ignored.
  - abort and poly_drawn in the same cycle: go to FINISH.
- Reset mid-walk returns to IDLE immediately. The parser is reset by the same reset_n, so no handshake cleanup is needed.
- entry_count saturates at MAX_ENTRIES.

Decomposition:
- Package pvr_ol_pkg holds:
  - OL type codes: OL_TRI_ARRAY=3'b100, OL_QUAD_ARRAY=3'b101, OL_RESERVED=3'b110, OL_LINK=3'b111.
  - Bit positions: strip flag bit31, EOL bit28, param offset field 20:0, link field 23:2.
  - State enum: IDLE, FETCH, DECODE, ISSUE, WAIT_POLY, FINISH.
- One sub-module, ol_entry_decode (combinational). Inputs: OL word, param_base. Outputs: is_poly, is_link, is_eol, is_reserved, poly_addr, link_addr. The same sub-module is reusable by the region-array walker.

Test Plan:
- Strip then EOL: param_base=0x100000, list {0x0C000010, 0xF0000000} → one render_poly with poly_addr=0x100040 and opb_word=0x0C000010; after poly_drawn, done with list_error=0 and entry_count=2.
- Array plus link: ol_base=0x200, list {0x8A000020, 0xE0000800}, then at 0x800 {0xF0000000} → poly_addr=param_base+0x80; next fetch at 0x204, then at 0x800; done with entry_count=3.
- VRAM stall: hold ol_vram_valid low for 5 cycles → ol_vram_rd and ol_vram_addr held stable; no render_poly until data arrives.
- Reserved type: word 0xC0000000 → no render_poly; done with list_error=1.
- Runaway guard: link at 0x300 pointing to itself (0xE0000300), MAX_ENTRIES=8 → done with list_error=1 after exactly 8 fetches.
- Abort and reset: abort during WAIT_POLY → done only after poly_drawn, no further fetch; reset_n low during FETCH → all outputs 0 asynchronously, state IDLE.
